// File: rtl/encoder_1hot_8to3.sv
// Registered 8-to-3 one-hot encoder with valid/ready on both sides.
// Flags non-one-hot words and keeps a saturating illegal-word count.
module encoder_1hot_8to3 #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out,
  output logic                 out_err,
  input  logic                 err_count_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic       accept;
  logic [7:0] low;
  logic [2:0] idx;
  logic       illegal;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Isolate the lowest set bit; it is one-hot or zero.
  assign low     = in & (~in + 8'd1);
  assign illegal = (in == 8'd0) || (low != in);

  always_comb begin
    idx = 3'd0;
    unique case (1'b1)
      low[0]:  idx = 3'd0;
      low[1]:  idx = 3'd1;
      low[2]:  idx = 3'd2;
      low[3]:  idx = 3'd3;
      low[4]:  idx = 3'd4;
      low[5]:  idx = 3'd5;
      low[6]:  idx = 3'd6;
      low[7]:  idx = 3'd7;
      default: idx = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out     <= 3'd0;
      out_err <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            out     <= idx;
            out_err <= illegal;
          end
        end
        FULL: begin
          if (accept) begin
            out     <= idx;
            out_err <= illegal;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if (accept && illegal && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_encoder_1hot_8to3.sv
// Scoreboard bench for encoder_1hot_8to3: random and directed words,
// checked against a counting reference model.
module tb_encoder_1hot_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_count_clr = 1'b0;
  logic [7:0] in_w = 8'd0;

  logic       in_ready, out_valid, out_err;
  logic [2:0] out_i;
  logic [7:0] err_count;

  logic       in_ready2, out_valid2, out_err2;
  logic [2:0] out2;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;

  logic [3:0] sb[$];
  int  m_cnt = 0;
  int  m_cnt2 = 0;
  bit  m_full = 0;

  always #5 clk = ~clk;

  encoder_1hot_8to3 #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_w),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out_i), .out_err(out_err),
    .err_count_clr(err_count_clr), .err_count(err_count)
  );

  encoder_1hot_8to3 #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in(in_w),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out(out2), .out_err(out_err2),
    .err_count_clr(err_count_clr), .err_count(err_count2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {err, index}: count the ones, take the first set bit from the bottom.
  function automatic logic [3:0] ref_enc(input logic [7:0] w);
    int ones = 0;
    int first = -1;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    return {ones != 1, 3'(first)};
  endfunction

  // Input side: model acceptance, push expectations, track counters.
  always begin
    logic [3:0] e;
    bit acc;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      m_full = 0;
      m_cnt = 0;
      m_cnt2 = 0;
    end else begin
      chk("err_count", int'(err_count), m_cnt);
      chk("err_count_w2", int'(err_count2), m_cnt2);
      e = ref_enc(in_w);
      acc = in_valid && (!m_full || out_ready);
      if (acc) sb.push_back(e);
      m_full = acc || (m_full && !out_ready);
      if (err_count_clr) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else if (acc && e[3]) begin
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
  end

  // Output side: pop on every handshake and compare.
  always begin
    logic [3:0] e;
    logic [3:0] held;
    bit hold;
    @(negedge clk);
    if (!rst_n) begin
      hold = 0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      chk("out_valid", int'(out_valid), int'(sb.size() != 0));
      if (hold) chk("stable", int'({out_err, out_i}), int'(held));
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", int'({out_err, out_i}), int'(e));
      end
      hold = out_valid && !out_ready;
      held = {out_err, out_i};
    end
  end

  task automatic step(input logic v, input logic [7:0] w,
                      input logic r, input logic c);
    in_valid = v;
    in_w = w;
    out_ready = r;
    err_count_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out"}, int'(out_i), 0);
    chk({tag, "_out_err"}, int'(out_err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] ill[3];
    logic [7:0] w;
    ill[0] = 8'h00;
    ill[1] = 8'h0C;
    ill[2] = 8'hFF;

    #1;
    chk_reset("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b1, 8'(1 << i), 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("sweep_err_count", int'(err_count), 0);

    for (int i = 0; i < 3; i++) step(1'b1, ill[i], 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("illegal_err_count", int'(err_count), 3);

    step(1'b1, 8'h10, 1'b1, 1'b0);
    repeat (5) step(1'b1, 8'h40, 1'b0, 1'b0);
    chk("bp_out", int'(out_i), 4);
    chk("bp_in_ready", int'(in_ready), 0);
    step(1'b1, 8'h40, 1'b1, 1'b0);
    chk("bp_next", int'(out_i), 6);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    step(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("sat_w2", int'(err_count2), 3);
    chk("sat_w8", int'(err_count), 5);

    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("clr_collision", int'(err_count), 0);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("clr_then_inc", int'(err_count), 1);

    step(1'b1, 8'h08, 1'b0, 1'b0);
    chk("pre_reset_valid", int'(out_valid), 1);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0, 1: w = 8'(1 << $urandom_range(0, 7));
        2: w = 8'h00;
        default: w = 8'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, w,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end

    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
